// File: rtl/etherneco_synctimer_trigger.sv
// Timed trigger generator fed by the EtherNeco sync-timer: fires at START, then every PERIOD, over a Wishbone register slave.
// Optional: define ETHERNECO_SYNCTIMER_TRIGGER_TIMESTAMP_EN to capture current_time at each fire (readable at 0x27/0x28).
module etherneco_synctimer_trigger #(
  parameter int TIMER_WIDTH  = 64,
  parameter int PERIOD_WIDTH = 32,
  parameter int PULSE_WIDTH  = 16,
  parameter int WB_ADR_WIDTH = 16,
  parameter int WB_DAT_WIDTH = 32,
  parameter int WB_SEL_WIDTH = WB_DAT_WIDTH/8
) (
  input  logic                    rst,
  input  logic                    clk,
  input  logic [WB_ADR_WIDTH-1:0] s_wb_adr_i,
  output logic [WB_DAT_WIDTH-1:0] s_wb_dat_o,
  input  logic [WB_DAT_WIDTH-1:0] s_wb_dat_i,
  input  logic [WB_SEL_WIDTH-1:0] s_wb_sel_i,
  input  logic                    s_wb_we_i,
  input  logic                    s_wb_stb_i,
  output logic                    s_wb_ack_o,
  input  logic [TIMER_WIDTH-1:0]  current_time,
  input  logic                    time_valid,
  output logic                    trigger,
  output logic                    trigger_event,
  output logic [31:0]             trigger_count
);

  typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_FIRE} state_e;

  localparam logic [31:0] CORE_ID_VAL = 32'hffff_1133;
  localparam logic [WB_ADR_WIDTH-1:0] ADR_CORE_ID    = 'h00;
  localparam logic [WB_ADR_WIDTH-1:0] ADR_CONTROL    = 'h10;
  localparam logic [WB_ADR_WIDTH-1:0] ADR_START_LO   = 'h20;
  localparam logic [WB_ADR_WIDTH-1:0] ADR_START_HI   = 'h21;
  localparam logic [WB_ADR_WIDTH-1:0] ADR_PERIOD     = 'h22;
  localparam logic [WB_ADR_WIDTH-1:0] ADR_PULSE      = 'h23;
  localparam logic [WB_ADR_WIDTH-1:0] ADR_STATUS     = 'h24;
  localparam logic [WB_ADR_WIDTH-1:0] ADR_COUNT      = 'h25;
  localparam logic [WB_ADR_WIDTH-1:0] ADR_STATUS_CLR = 'h26;

  state_e                  state_q;
  logic                    enable_q, oneshot_q, missed_q;
  logic [31:0]             start_lo_q, start_hi_q, count_q;
  logic [PERIOD_WIDTH-1:0] period_q;
  logic [PULSE_WIDTH-1:0]  pulse_q, pulse_cnt_q;
  logic [TIMER_WIDTH-1:0]  next_time_q;
  logic                    trigger_q, trigger_event_q;

  logic [31:0]             wr_data, rd_data;
  logic [3:0]              wr_sel;
  logic                    wr_en, ctrl_wr, enable_wr, oneshot_wr, arm, disarm;
  logic [63:0]             start_full;
  logic [TIMER_WIDTH-1:0]  start_time, time_diff;
  logic                    reached, late, fire_stop;
  logic [PULSE_WIDTH-1:0]  pulse_load;

  function automatic logic [31:0] wmask(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] sel);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = sel[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    return r;
  endfunction

  assign wr_data    = 32'(s_wb_dat_i);
  assign wr_sel     = 4'(s_wb_sel_i);
  assign wr_en      = s_wb_stb_i && s_wb_we_i;
  assign ctrl_wr    = wr_en && (s_wb_adr_i == ADR_CONTROL);
  assign enable_wr  = wr_sel[0] ? wr_data[0] : enable_q;
  assign oneshot_wr = wr_sel[0] ? wr_data[1] : oneshot_q;
  // Arming is edge-triggered on the enable bit; a disable write aborts from any state.
  assign arm        = ctrl_wr && enable_wr && !enable_q && (state_q == ST_IDLE);
  assign disarm     = ctrl_wr && !enable_wr;

  assign start_full = {start_hi_q, start_lo_q};
  assign start_time = start_full[TIMER_WIDTH-1:0];
  // Modular distance: the MSB tells "not yet" from "reached" across timer wrap.
  assign time_diff  = current_time - next_time_q;
  assign reached    = !time_diff[TIMER_WIDTH-1];
  assign late       = reached && (period_q != '0) && (time_diff >= TIMER_WIDTH'(period_q));
  assign fire_stop  = oneshot_q || (period_q == '0);
  assign pulse_load = (pulse_q == '0) ? PULSE_WIDTH'(1) : pulse_q;

  always_ff @(posedge clk) begin
    // NOTE: rst is synchronous, so it appears only inside the clocked branch, never in the sensitivity list.
    if (rst) begin
      state_q         <= ST_IDLE;
      enable_q        <= 1'b0;
      oneshot_q       <= 1'b0;
      missed_q        <= 1'b0;
      start_lo_q      <= '0;
      start_hi_q      <= '0;
      count_q         <= '0;
      period_q        <= '0;
      pulse_q         <= '0;
      pulse_cnt_q     <= '0;
      next_time_q     <= '0;
      trigger_q       <= 1'b0;
      trigger_event_q <= 1'b0;
    end else begin
      // NOTE: non-blocking updates let later statements override earlier defaults; priority is textual order.
      trigger_event_q <= 1'b0;
      trigger_q       <= pulse_cnt_q > PULSE_WIDTH'(1);
      pulse_cnt_q     <= (pulse_cnt_q != '0) ? pulse_cnt_q - PULSE_WIDTH'(1) : '0;

      if (wr_en) begin
        case (s_wb_adr_i)
          ADR_CONTROL: begin
            enable_q  <= enable_wr;
            oneshot_q <= oneshot_wr;
          end
          ADR_START_LO:   start_lo_q <= wmask(start_lo_q, wr_data, wr_sel);
          ADR_START_HI:   start_hi_q <= wmask(start_hi_q, wr_data, wr_sel);
          ADR_PERIOD:     period_q   <= PERIOD_WIDTH'(wmask(32'(period_q), wr_data, wr_sel));
          ADR_PULSE:      pulse_q    <= PULSE_WIDTH'(wmask(32'(pulse_q), wr_data, wr_sel));
          ADR_STATUS_CLR: if (wr_sel[0] && wr_data[1]) missed_q <= 1'b0;
          default: ;
        endcase
      end

      case (state_q)
        ST_IDLE: begin
          if (arm) begin
            next_time_q <= start_time;
            count_q     <= '0;
            state_q     <= ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (reached && time_valid) begin
            state_q         <= ST_FIRE;
            trigger_event_q <= 1'b1;
          end
        end
        ST_FIRE: begin
          count_q     <= count_q + 32'd1;
          pulse_cnt_q <= pulse_load;
          trigger_q   <= 1'b1;
          next_time_q <= next_time_q + TIMER_WIDTH'(period_q);
          if (late) missed_q <= 1'b1;
          if (fire_stop) begin
            enable_q <= 1'b0;
            state_q  <= ST_IDLE;
          end else begin
            state_q <= ST_ARMED;
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      if (disarm) begin
        state_q         <= ST_IDLE;
        pulse_cnt_q     <= '0;
        trigger_q       <= 1'b0;
        trigger_event_q <= 1'b0;
      end
    end
  end

`ifdef ETHERNECO_SYNCTIMER_TRIGGER_TIMESTAMP_EN
  localparam logic [WB_ADR_WIDTH-1:0] ADR_TS_LO = 'h27;
  localparam logic [WB_ADR_WIDTH-1:0] ADR_TS_HI = 'h28;
  logic [TIMER_WIDTH-1:0] stamp_q;
  logic [63:0]            stamp_rd;

  always_ff @(posedge clk) begin
    if (rst || arm)               stamp_q <= '0;
    else if (state_q == ST_FIRE)  stamp_q <= current_time;
  end
  assign stamp_rd = 64'(stamp_q);
`endif

  always_comb begin
    // NOTE: a default before the case keeps this purely combinational (no latch on unlisted addresses).
    rd_data = '0;
    case (s_wb_adr_i)
      ADR_CORE_ID:  rd_data = CORE_ID_VAL;
      ADR_CONTROL:  rd_data = {30'd0, oneshot_q, enable_q};
      ADR_START_LO: rd_data = start_lo_q;
      ADR_START_HI: rd_data = start_hi_q;
      ADR_PERIOD:   rd_data = 32'(period_q);
      ADR_PULSE:    rd_data = 32'(pulse_q);
      ADR_STATUS:   rd_data = {30'd0, missed_q, state_q != ST_IDLE};
      ADR_COUNT:    rd_data = count_q;
`ifdef ETHERNECO_SYNCTIMER_TRIGGER_TIMESTAMP_EN
      ADR_TS_LO:    rd_data = stamp_rd[31:0];
      ADR_TS_HI:    rd_data = stamp_rd[63:32];
`endif
      default:      rd_data = '0;
    endcase
  end

  assign s_wb_dat_o    = WB_DAT_WIDTH'(rd_data);
  assign s_wb_ack_o    = s_wb_stb_i;
  assign trigger       = trigger_q;
  assign trigger_event = trigger_event_q;
  assign trigger_count = count_q;

endmodule

// File: tb/tb_etherneco_synctimer_trigger.sv
// Self-checking bench for etherneco_synctimer_trigger: directed scenarios plus randomized ones against an event-level model.
module tb_etherneco_synctimer_trigger;

  localparam int LMAX = 2200;
  localparam logic [15:0] A_CORE = 16'h00, A_CTRL = 16'h10, A_SLO = 16'h20, A_SHI = 16'h21;
  localparam logic [15:0] A_PER  = 16'h22, A_PUL  = 16'h23, A_STAT = 16'h24, A_SCLR = 16'h26;
  localparam logic [15:0] A_TSLO = 16'h27, A_TSHI = 16'h28, A_NONE = 16'h30;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] s_wb_adr_i;
  logic [31:0] s_wb_dat_o, s_wb_dat_i;
  logic [3:0]  s_wb_sel_i;
  logic        s_wb_we_i, s_wb_stb_i, s_wb_ack_o;
  logic [63:0] current_time;
  logic        time_valid, trigger, trigger_event;
  logic [31:0] trigger_count;

  logic [63:0] time_at    [LMAX];
  bit          valid_at   [LMAX];
  bit          exp_ev     [LMAX];
  bit          exp_trig   [LMAX];
  bit          exp_armed  [LMAX];
  bit          exp_missed [LMAX];
  int          exp_cnt    [LMAX];
  logic [63:0] model_stamp;
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] rd;

  etherneco_synctimer_trigger dut (
    .rst(rst), .clk(clk),
    .s_wb_adr_i(s_wb_adr_i), .s_wb_dat_o(s_wb_dat_o), .s_wb_dat_i(s_wb_dat_i),
    .s_wb_sel_i(s_wb_sel_i), .s_wb_we_i(s_wb_we_i), .s_wb_stb_i(s_wb_stb_i),
    .s_wb_ack_o(s_wb_ack_o),
    .current_time(current_time), .time_valid(time_valid),
    .trigger(trigger), .trigger_event(trigger_event), .trigger_count(trigger_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp_v);
    n_checks++;
    if (got === exp_v) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp_v);
  endtask

  task automatic to_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_write(input logic [15:0] adr, input logic [31:0] data, input logic [3:0] sel = 4'hf);
    s_wb_adr_i = adr; s_wb_dat_i = data; s_wb_sel_i = sel; s_wb_we_i = 1'b1; s_wb_stb_i = 1'b1;
    to_drive();
    s_wb_we_i = 1'b0; s_wb_stb_i = 1'b0;
  endtask

  task automatic wb_read(input logic [15:0] adr, output logic [31:0] data);
    s_wb_adr_i = adr; s_wb_we_i = 1'b0; s_wb_stb_i = 1'b1;
    #1;
    data = s_wb_dat_o;
  endtask

  // step_mode: 0 frozen time, 1 +1 per cycle, 2 random +0..2; rnd_valid drops time_valid ~10% of cycles.
  task automatic fill_time(input logic [63:0] t0, input int step_mode, input bit rnd_valid);
    for (int c = 0; c < LMAX; c++) begin
      if (c == 0)             time_at[c] = t0;
      else if (step_mode == 0) time_at[c] = time_at[c-1];
      else if (step_mode == 1) time_at[c] = time_at[c-1] + 64'd1;
      else                     time_at[c] = time_at[c-1] + 64'($urandom_range(0, 2));
      valid_at[c] = rnd_valid ? ($urandom_range(0, 9) != 0) : 1'b1;
    end
  endtask

  // Event-level prediction: cycle 0 is the arming write; an event is due in the cycle after
  // an armed cycle whose time has reached the target, and the next target is looked at the cycle after that.
  task automatic build_model(input logic [63:0] start, input logic [31:0] period, input int pulse,
                             input bit oneshot, input int len);
    logic [63:0] nxt, d;
    int c, e, w, cnt;
    bit active;
    for (int i = 0; i < len; i++) begin
      exp_ev[i] = 0; exp_trig[i] = 0; exp_missed[i] = 0; exp_cnt[i] = 0; exp_armed[i] = (i >= 1);
    end
    nxt = start; cnt = 0; active = 1; c = 1; w = (pulse == 0) ? 1 : pulse;
    model_stamp = '0;
    while (active && c + 1 < len) begin
      d = time_at[c] - nxt;
      if (!d[63] && valid_at[c]) begin
        e = c + 1;
        exp_ev[e] = 1;
        model_stamp = time_at[e];
        d = time_at[e] - nxt;
        cnt++;
        for (int i = e + 1; i < len; i++) begin
          exp_cnt[i] = cnt;
          if (period != 0 && !d[63] && d >= 64'(period)) exp_missed[i] = 1;
          if (i <= e + w) exp_trig[i] = 1;
          if (oneshot || period == 0) exp_armed[i] = 0;
        end
        nxt = nxt + 64'(period);
        if (oneshot || period == 0) active = 0;
        c = e + 1;
      end else begin
        c++;
      end
    end
  endtask

  task automatic run_scen(input string name, input logic [63:0] start, input logic [31:0] period,
                          input logic [15:0] pulse, input bit oneshot, input int len);
    current_time = time_at[0];
    time_valid   = 1'b0;
    wb_write(A_CTRL, 32'h0);
    wb_write(A_SCLR, 32'h2);
    wb_write(A_SLO, start[31:0]);
    wb_write(A_SHI, start[63:32]);
    wb_write(A_PER, period);
    wb_write(A_PUL, {16'h0, pulse});
    build_model(start, period, int'(pulse), oneshot, len);
    time_valid = valid_at[0];
    wb_write(A_CTRL, {30'd0, oneshot, 1'b1});
    for (int c = 1; c < len; c++) begin
      current_time = time_at[c];
      time_valid   = valid_at[c];
      s_wb_adr_i = A_STAT; s_wb_we_i = 1'b0; s_wb_stb_i = 1'b1;
      @(negedge clk);
      check($sformatf("%s.event@%0d", name, c), trigger_event, exp_ev[c]);
      check($sformatf("%s.trigger@%0d", name, c), trigger, exp_trig[c]);
      check($sformatf("%s.count@%0d", name, c), trigger_count, 32'(exp_cnt[c]));
      check($sformatf("%s.status@%0d", name, c), s_wb_dat_o, {30'd0, exp_missed[c], exp_armed[c]});
      to_drive();
    end
    s_wb_stb_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1; s_wb_adr_i = '0; s_wb_dat_i = '0; s_wb_sel_i = '0; s_wb_we_i = 1'b0; s_wb_stb_i = 1'b0;
    current_time = '0; time_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset.trigger", trigger, 1'b0);
    check("reset.event", trigger_event, 1'b0);
    check("reset.count", trigger_count, 32'd0);
    wb_read(A_STAT, rd); check("reset.status", rd, 32'd0);
    wb_read(A_CTRL, rd); check("reset.control", rd, 32'd0);
    check("ack", s_wb_ack_o, 1'b1);
    to_drive();
    wb_read(A_PER, rd);  check("reset.period", rd, 32'd0);
    wb_read(A_CORE, rd); check("core_id", rd, 32'hffff_1133);
    wb_read(A_NONE, rd); check("unmapped", rd, 32'd0);
    to_drive();

    // Byte-masked writes and narrow registers.
    wb_write(A_PER, 32'h1122_3344);
    wb_write(A_PER, 32'hAABB_CCDD, 4'b0101);
    wb_read(A_PER, rd); check("period.bytemask", rd, 32'h11BB_33DD);
    to_drive();
    wb_write(A_PUL, 32'hDEAD_BEEF);
    wb_write(A_NONE, 32'h1234_5678);
    wb_read(A_PUL, rd);  check("pulse.narrow", rd, 32'h0000_BEEF);
    wb_read(A_NONE, rd); check("unmapped.write", rd, 32'd0);
    to_drive();

    // Periodic firing from time 0.
    fill_time(64'd0, 1, 1'b0);
    run_scen("periodic", 64'd1000, 32'd500, 16'd4, 1'b0, 2100);
    check("periodic.count3", trigger_count, 32'd3);
`ifdef ETHERNECO_SYNCTIMER_TRIGGER_TIMESTAMP_EN
    wb_read(A_TSLO, rd); check("stamp.lo", rd, model_stamp[31:0]);
    wb_read(A_TSHI, rd); check("stamp.hi", rd, model_stamp[63:32]);
`else
    wb_read(A_TSLO, rd); check("stamp.lo.absent", rd, 32'd0);
    wb_read(A_TSHI, rd); check("stamp.hi.absent", rd, 32'd0);
`endif
    to_drive();

    // One-shot clears enable and disarms.
    fill_time(64'd0, 1, 1'b0);
    run_scen("oneshot", 64'd200, 32'd50, 16'd2, 1'b1, 400);
    wb_read(A_CTRL, rd); check("oneshot.control", rd, 32'h2);
    wb_read(A_STAT, rd); check("oneshot.status", rd, 32'h0);
    to_drive();

    // Time wraps through zero before reaching START.
    fill_time(64'hFFFF_FFFF_FFFF_FF9C, 1, 1'b0);
    run_scen("wrap", 64'd50, 32'd100, 16'd3, 1'b0, 200);

    // Backlog with frozen time: back-to-back fires, missed set, then cleared.
    fill_time(64'd135, 0, 1'b0);
    run_scen("backlog", 64'd100, 32'd10, 16'd3, 1'b0, 20);
    check("backlog.count4", trigger_count, 32'd4);
    wb_read(A_STAT, rd); check("backlog.missed", rd, 32'h3);
    to_drive();
    wb_write(A_SCLR, 32'h2);
    wb_read(A_STAT, rd); check("backlog.cleared", rd, 32'h1);
    to_drive();

    // time_valid held low across START, released at 320.
    fill_time(64'd0, 1, 1'b0);
    for (int c = 0; c < LMAX; c++) valid_at[c] = (c >= 320);
    run_scen("valid_gate", 64'd300, 32'd1000, 16'd2, 1'b0, 400);

    // Disable while the pulse is high, then re-arm.
    fill_time(64'd0, 1, 1'b0);
    run_scen("disable", 64'd50, 32'd1000, 16'd100, 1'b0, 80);
    check("disable.pre_trigger", trigger, 1'b1);
    wb_write(A_CTRL, 32'h0);
    check("disable.trigger", trigger, 1'b0);
    check("disable.count_kept", trigger_count, 32'd1);
    wb_write(A_CTRL, 32'h1);
    check("rearm.count", trigger_count, 32'd0);
    wb_read(A_STAT, rd); check("rearm.armed", rd, 32'h1);
    to_drive();

    // Randomized scenarios.
    for (int k = 0; k < 6; k++) begin
      logic [63:0] t0, st;
      t0 = {$urandom(), $urandom()};
      fill_time(t0, 2, 1'b1);
      st = t0 + 64'($urandom_range(0, 260)) - 64'd60;
      run_scen($sformatf("rnd%0d", k), st, 32'($urandom_range(0, 40)),
               16'($urandom_range(0, 8)), ($urandom_range(0, 3) == 0), 300);
    end

    // Reset in the middle of a pulse.
    fill_time(64'd0, 1, 1'b0);
    run_scen("rst_pulse", 64'd5, 32'd1000, 16'd50, 1'b0, 20);
    check("rst_pulse.pre", trigger, 1'b1);
    rst = 1'b1;
    to_drive();
    check("rst_pulse.trigger", trigger, 1'b0);
    check("rst_pulse.count", trigger_count, 32'd0);
    rst = 1'b0;
    to_drive();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
